discrete_range_sequencer: RTL and testbench

//  Sequences one "inside" draw for an integer variable in the discrete range randomizer.
//  On start it picks a uniformly random choice index, reads that choice's [start:end] pair

---
 rtl/discrete_range_sequencer.sv | 169 ++++++++++++++++
 tb/tb_discrete_range_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/discrete_range_sequencer.sv
// discrete_range_sequencer
//   Sequences one "inside" draw for an integer variable: picks a uniformly
//   random choice index, reads that choice's [start:end] pair from the
//   discrete values table and returns a uniformly random value in the range.
//   Rejection sampling with a deterministic fallback bounds the latency.
// Ports
//   in_clock, in_reset_n           clock (rising edge), async active-low reset
//   in_start                       request pulse, sampled only in IDLE
//   in_variable_index              variable to randomize (latched on start)
//   in_number_of_choices           valid choices, 1..2**CH (0 -> error)
//   in_random                      free-running random word
//   out_table_enable               table read enable, high only in READ
//   out_table_variable_index       table address, upper field
//   out_table_choice_index         table address, lower field
//   in_table_start, in_table_end   table range, valid the cycle after enable
//   out_busy                       high in every state except IDLE
//   out_valid                      one-cycle result strobe
//   out_value, out_error           result, held until the next out_valid
module discrete_range_sequencer #(
    parameter int MAX_BIT_WIDTH_OF_INTEGER_VARIABLE = 8,
    parameter int MAX_BIT_WIDTH_OF_VARIABLES_INDEX  = 8,
    parameter int MAX_BIT_WIDTH_OF_DISCRETE_CHOICES = 4,
    parameter int MAX_RETRIES                       = 3
) (
    input  logic                                         in_clock,
    input  logic                                         in_reset_n,
    input  logic                                         in_start,
    input  logic [MAX_BIT_WIDTH_OF_VARIABLES_INDEX-1:0]  in_variable_index,
    input  logic [MAX_BIT_WIDTH_OF_DISCRETE_CHOICES:0]   in_number_of_choices,
    input  logic [MAX_BIT_WIDTH_OF_INTEGER_VARIABLE-1:0] in_random,
    output logic                                         out_table_enable,
    output logic [MAX_BIT_WIDTH_OF_VARIABLES_INDEX-1:0]  out_table_variable_index,
    output logic [MAX_BIT_WIDTH_OF_DISCRETE_CHOICES-1:0] out_table_choice_index,
    input  logic [MAX_BIT_WIDTH_OF_INTEGER_VARIABLE-1:0] in_table_start,
    input  logic [MAX_BIT_WIDTH_OF_INTEGER_VARIABLE-1:0] in_table_end,
    output logic                                         out_busy,
    output logic                                         out_valid,
    output logic [MAX_BIT_WIDTH_OF_INTEGER_VARIABLE-1:0] out_value,
    output logic                                         out_error
);
    localparam int INT = MAX_BIT_WIDTH_OF_INTEGER_VARIABLE;
    localparam int VI  = MAX_BIT_WIDTH_OF_VARIABLES_INDEX;
    localparam int CH  = MAX_BIT_WIDTH_OF_DISCRETE_CHOICES;
    localparam int RW  = $clog2(MAX_RETRIES) + 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SELECT = 3'd1;
    localparam logic [2:0] S_READ   = 3'd2;
    localparam logic [2:0] S_LATCH  = 3'd3;
    localparam logic [2:0] S_RANGE  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    // Bit-smear: smallest 2**k-1 that is >= n.
    function automatic logic [INT-1:0] smear_int(input logic [INT-1:0] n);
        logic [INT-1:0] m;
        m = n;
        for (int i = 1; i < INT; i = i * 2) m = m | (m >> i);
        return m;
    endfunction

    function automatic logic [CH-1:0] smear_ch(input logic [CH-1:0] n);
        logic [CH-1:0] m;
        m = n;
        for (int i = 1; i < CH; i = i * 2) m = m | (m >> i);
        return m;
    endfunction

    logic [2:0]     state;
    logic [RW-1:0]  retry_q;
    logic [VI-1:0]  index_q;
    logic [CH:0]    count_q;
    logic [INT-1:0] start_q;
    logic [INT-1:0] span_q;

    logic           last_try;
    logic [CH-1:0]  count_m1;
    logic [CH-1:0]  c_draw;
    logic [CH-1:0]  c_fb;
    logic           c_ok;
    logic [INT-1:0] o_draw;
    logic           o_ok;
    logic [INT-1:0] val_acc;
    logic [INT-1:0] val_fb;

    assign last_try = (retry_q == RW'(MAX_RETRIES - 1));
    // count==2**CH wraps to all ones in CH bits, which is exactly count-1.
    assign count_m1 = count_q[CH-1:0] - CH'(1);
    assign c_draw   = in_random[CH-1:0] & smear_ch(count_m1);
    assign c_ok     = ({1'b0, c_draw} < count_q);
    // Only used when c_draw >= count, so count < 2**CH and fits CH bits.
    assign c_fb     = c_draw - count_q[CH-1:0];
    assign o_draw   = in_random & smear_int(span_q);
    assign o_ok     = (o_draw <= span_q);
    assign val_acc  = start_q + o_draw;
    assign val_fb   = start_q + o_draw - span_q - INT'(1);

    assign out_table_enable = (state == S_READ);
    assign out_busy         = (state != S_IDLE);
    assign out_valid        = (state == S_DONE);

    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state                    <= S_IDLE;
            retry_q                  <= '0;
            index_q                  <= '0;
            count_q                  <= '0;
            start_q                  <= '0;
            span_q                   <= '0;
            out_table_variable_index <= '0;
            out_table_choice_index   <= '0;
            out_value                <= '0;
            out_error                <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_start) begin
                        index_q <= in_variable_index;
                        count_q <= in_number_of_choices;
                        retry_q <= '0;
                        state   <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (count_q == '0) begin
                        out_error <= 1'b1;
                        out_value <= '0;
                        state     <= S_DONE;
                    end else if (c_ok || last_try) begin
                        out_table_variable_index <= index_q;
                        out_table_choice_index   <= c_ok ? c_draw : c_fb;
                        state                    <= S_READ;
                    end else begin
                        retry_q <= retry_q + RW'(1);
                    end
                end
                S_READ: begin
                    retry_q <= '0;
                    state   <= S_LATCH;
                end
                S_LATCH: begin
                    start_q <= in_table_start;
                    span_q  <= in_table_end - in_table_start;
                    if (in_table_start > in_table_end) begin
                        out_error <= 1'b1;
                        out_value <= in_table_start;
                        state     <= S_DONE;
                    end else begin
                        state <= S_RANGE;
                    end
                end
                S_RANGE: begin
                    if (o_ok) begin
                        out_value <= val_acc;
                        out_error <= 1'b0;
                        state     <= S_DONE;
                    end else if (last_try) begin
                        out_value <= val_fb;
                        out_error <= 1'b0;
                        state     <= S_DONE;
                    end else begin
                        retry_q <= retry_q + RW'(1);
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_discrete_range_sequencer.sv
// tb_discrete_range_sequencer
//   Directed scenarios plus randomized draws against a behavioural model of
//   the draw rules. The random word presented in each cycle after start is
//   taken from a per-draw word list so the model can replay the draw.
module tb_discrete_range_sequencer;
    localparam int MR = 3;

    logic       in_clock = 1'b0;
    logic       in_reset_n = 1'b0;
    logic       in_start = 1'b0;
    logic [7:0] in_variable_index = '0;
    logic [4:0] in_number_of_choices = '0;
    logic [7:0] in_random = '0;
    logic       out_table_enable;
    logic [7:0] out_table_variable_index;
    logic [3:0] out_table_choice_index;
    logic [7:0] in_table_start = '0;
    logic [7:0] in_table_end = '0;
    logic       out_busy;
    logic       out_valid;
    logic [7:0] out_value;
    logic       out_error;

    discrete_range_sequencer #(
        .MAX_BIT_WIDTH_OF_INTEGER_VARIABLE(8),
        .MAX_BIT_WIDTH_OF_VARIABLES_INDEX (8),
        .MAX_BIT_WIDTH_OF_DISCRETE_CHOICES(4),
        .MAX_RETRIES                      (MR)
    ) dut (
        .in_clock                (in_clock),
        .in_reset_n              (in_reset_n),
        .in_start                (in_start),
        .in_variable_index       (in_variable_index),
        .in_number_of_choices    (in_number_of_choices),
        .in_random               (in_random),
        .out_table_enable        (out_table_enable),
        .out_table_variable_index(out_table_variable_index),
        .out_table_choice_index  (out_table_choice_index),
        .in_table_start          (in_table_start),
        .in_table_end            (in_table_end),
        .out_busy                (out_busy),
        .out_valid               (out_valid),
        .out_value               (out_value),
        .out_error               (out_error)
    );

    always #5 in_clock = ~in_clock;

    logic [7:0] tbl_s [0:255][0:15];
    logic [7:0] tbl_e [0:255][0:15];

    // Registered table: data appears the cycle after the enable.
    always @(posedge in_clock) begin
        if (out_table_enable) begin
            in_table_start <= tbl_s[out_table_variable_index][out_table_choice_index];
            in_table_end   <= tbl_e[out_table_variable_index][out_table_choice_index];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int mk(input int n);
        int m = 0;
        while (m < n) m = m * 2 + 1;
        return m;
    endfunction

    logic [7:0] w [0:15];
    int r_val, r_cyc;

    task automatic fill_words();
        for (int i = 0; i < 16; i++) w[i] = 8'($urandom);
    endtask

    task automatic run_draw(input int vi, input int cnt);
        int j, c, st, en, span, m, o, ev, ee, ecyc, ens;
        bit got;
        j = 0; c = 0; ev = 0; ee = 0;
        if (cnt == 0) begin
            ecyc = 1; ev = 0; ee = 1;
        end else begin
            for (int k = 0; k < MR; k++) begin
                c = int'(w[j][3:0]) & mk(cnt - 1);
                j++;
                if (c < cnt) break;
                if (k == MR - 1) c = c - cnt;
            end
            j += 2;
            st = tbl_s[vi][c];
            en = tbl_e[vi][c];
            if (st > en) begin
                ee = 1; ev = st;
            end else begin
                span = en - st;
                m = mk(span);
                for (int k = 0; k < MR; k++) begin
                    o = int'(w[j]) & m;
                    j++;
                    if (o <= span) begin ev = st + o; break; end
                    if (k == MR - 1) ev = st + o - span - 1;
                end
            end
            ecyc = j;
        end
        @(negedge in_clock);
        in_start = 1'b1;
        in_variable_index = 8'(vi);
        in_number_of_choices = 5'(cnt);
        @(posedge in_clock); #1;
        in_start = 1'b0;
        in_random = w[0];
        got = 1'b0; ens = 0; r_cyc = -1; r_val = -1;
        for (int cyc = 1; cyc < 20 && !got; cyc++) begin
            @(posedge in_clock); #1;
            if (out_table_enable) begin
                ens++;
                chk("addr", {out_table_variable_index, out_table_choice_index}, 32'((vi << 4) | c));
            end
            if (out_valid) begin
                got = 1'b1;
                r_cyc = cyc; r_val = out_value;
                chk("latency", cyc + 1, ecyc + 1);
                chk("value", out_value, ev);
                chk("error", out_error, ee);
            end
            in_random = w[cyc];
        end
        chk("valid_seen", got, 1);
        chk("enable_pulses", ens, (cnt != 0) ? 1 : 0);
        @(posedge in_clock); #1;
        chk("idle_busy", out_busy, 0);
        chk("value_held", out_value, ev);
    endtask

    initial begin
        int vlds, lows;
        bit got;
        for (int a = 0; a < 256; a++)
            for (int b = 0; b < 16; b++) begin
                tbl_s[a][b] = 8'($urandom);
                tbl_e[a][b] = 8'($urandom);
            end
        tbl_s[5][2] = 10;  tbl_e[5][2] = 20;
        tbl_s[3][2] = 40;  tbl_e[3][2] = 47;
        tbl_s[9][0] = 100; tbl_e[9][0] = 100;
        tbl_s[9][1] = 0;   tbl_e[9][1] = 255;
        tbl_s[7][0] = 30;  tbl_e[7][0] = 10;

        #12;
        chk("reset_outs", {out_valid, out_busy, out_table_enable, out_error, out_value,
                           out_table_variable_index, out_table_choice_index}, 0);
        @(negedge in_clock); in_reset_n = 1'b1;

        // T1
        fill_words(); w[0] = 8'h32; w[3] = 8'h47;
        run_draw(5, 4);
        chk("t1_value", r_val, 17);
        chk("t1_cycle", r_cyc + 1, 5);

        // T2: choice fallback 6,7,7 -> c=2
        fill_words(); w[0] = 6; w[1] = 7; w[2] = 7; w[5] = 3;
        run_draw(3, 5);
        chk("t2_value", r_val, 43);
        chk("t2_cycle", r_cyc + 1, 7);

        // T3
        fill_words(); w[0] = 8'hF0;
        run_draw(9, 1);
        chk("t3_point", r_val, 100);
        chk("t3_point_cycle", r_cyc + 1, 5);
        fill_words(); w[0] = 1; w[3] = 8'hFF;
        run_draw(9, 2);
        chk("t3_full", r_val, 255);

        // T4
        fill_words();
        run_draw(4, 0);
        chk("t4_zero_cycle", r_cyc + 1, 2);
        fill_words(); w[0] = 0;
        run_draw(7, 1);
        chk("t4_bad_value", r_val, 30);

        // T5: start held high
        @(negedge in_clock);
        in_start = 1'b1; in_variable_index = 8'd5; in_number_of_choices = 5'd4;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(posedge in_clock); #1; in_random = 8'($urandom);
            if (out_valid) got = 1'b1;
        end
        chk("t5_first_valid", got, 1);
        vlds = 0; lows = 0;
        for (int i = 0; i < 60 && vlds < 3; i++) begin
            @(posedge in_clock); #1; in_random = 8'($urandom);
            if (!out_busy) lows++;
            if (out_valid) begin
                vlds++;
                if (!out_busy) chk("t5_valid_busy", out_busy, 1);
            end
        end
        in_start = 1'b0;
        chk("t5_valids", vlds, 3);
        chk("t5_idle_cycles", lows, 3);
        @(posedge in_clock); @(posedge in_clock); #1;
        chk("t5_idle_after", out_busy, 0);

        // T6: reset in LATCH
        @(negedge in_clock);
        in_start = 1'b1; in_variable_index = 8'd5; in_number_of_choices = 5'd4;
        @(posedge in_clock); #1; in_start = 1'b0; in_random = 8'd2;
        @(posedge in_clock); #1;
        chk("t6_read", out_table_enable, 1);
        @(posedge in_clock); #1;
        in_reset_n = 1'b0; #1;
        chk("t6_reset_outs", {out_valid, out_busy, out_table_enable, out_error, out_value,
                              out_table_variable_index, out_table_choice_index}, 0);
        vlds = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge in_clock); #1;
            if (out_valid) vlds++;
        end
        chk("t6_no_valid", vlds, 0);
        @(negedge in_clock); in_reset_n = 1'b1;
        fill_words(); w[0] = 8'h32; w[3] = 8'h47;
        run_draw(5, 4);
        chk("t6_after_value", r_val, 17);

        // Randomized draws
        for (int n = 0; n < 60; n++) begin
            fill_words();
            if (n % 3 == 0) begin
                // Small spans exercise the range rejection/fallback path.
                int a, b;
                a = $urandom_range(255); b = $urandom_range(255);
                tbl_s[a][b % 16] = 8'($urandom_range(200));
                tbl_e[a][b % 16] = tbl_s[a][b % 16] + 8'($urandom_range(20));
            end
            run_draw($urandom_range(255), $urandom_range(16));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
